// File: rtl/tmr_voter_seq.sv
// Triple-modular-redundancy voter with a one-cycle registered result and a per-channel health FSM.
// Build option: define TMR_VOTER_STATS_EN to add saturating per-channel mismatch counters.

module tmr_voter_chan #(
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             mis_in,
  input  logic             clr_fault,
  output logic             failed,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [1:0] ST_HEALTHY = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_FAILED  = 2'd2;
  localparam logic [7:0] THRESH     = 8'(FAULT_THRESH);

  logic [1:0] state_q, state_d;
  logic [7:0] run_q, run_d;
  logic [7:0] run_inc;

  assign run_inc = run_q + 8'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    // clr_fault wins over a same-cycle mismatch; stats still see that mismatch
    if (clr_fault) begin
      state_d = ST_HEALTHY;
      run_d   = 8'd0;
    end else if (valid_in) begin
      case (state_q)
        ST_HEALTHY: begin
          if (mis_in) begin
            run_d   = 8'd1;
            state_d = (THRESH == 8'd1) ? ST_FAILED : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (mis_in) begin
            run_d = run_inc;
            if (run_inc == THRESH) state_d = ST_FAILED;
          end else begin
            run_d   = 8'd0;
            state_d = ST_HEALTHY;
          end
        end
        ST_FAILED: ;
        default: begin
          state_d = ST_HEALTHY;
          run_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HEALTHY;
      run_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign failed = (state_q == ST_FAILED);

`ifdef TMR_VOTER_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (valid_in && mis_in && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif
endmodule

module tmr_voter_seq #(
  parameter int WIDTH        = 4,
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  input  logic             clr_fault,
  output logic [WIDTH-1:0] tmr_out,
  output logic             valid_out,
  output logic [2:0]       mismatch,
  output logic             multi_err,
  output logic [2:0]       fault,
  output logic [CNT_W-1:0] err_cnt_1,
  output logic [CNT_W-1:0] err_cnt_2,
  output logic [CNT_W-1:0] err_cnt_3
);
  logic [2:0][WIDTH-1:0] data_all;
  logic [WIDTH-1:0]      vote_c;
  logic [2:0]            mis_c;
  logic                  multi_c;
  logic [2:0][CNT_W-1:0] err_cnt_w;

  assign data_all = {data_3, data_2, data_1};
  assign vote_c   = (data_1 & data_2) | (data_1 & data_3) | (data_2 & data_3);
  assign multi_c  = (mis_c[0] & mis_c[1]) | (mis_c[0] & mis_c[2]) | (mis_c[1] & mis_c[2]);

  logic [WIDTH-1:0] tmr_out_q, tmr_out_d;
  logic             valid_out_q, valid_out_d;
  logic [2:0]       mismatch_q, mismatch_d;
  logic             multi_err_q, multi_err_d;

  always_comb begin
    valid_out_d = valid_in;
    tmr_out_d   = tmr_out_q;
    mismatch_d  = mismatch_q;
    multi_err_d = multi_err_q;
    if (valid_in) begin
      tmr_out_d   = vote_c;
      mismatch_d  = mis_c;
      multi_err_d = multi_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_q <= 1'b0;
      tmr_out_q   <= '0;
      mismatch_q  <= 3'b000;
      multi_err_q <= 1'b0;
    end else begin
      valid_out_q <= valid_out_d;
      tmr_out_q   <= tmr_out_d;
      mismatch_q  <= mismatch_d;
      multi_err_q <= multi_err_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    assign mis_c[i] = |(data_all[i] ^ vote_c);

    tmr_voter_chan #(
      .FAULT_THRESH (FAULT_THRESH),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .mis_in    (mis_c[i]),
      .clr_fault (clr_fault),
      .failed    (fault[i]),
      .err_cnt   (err_cnt_w[i])
    );
  end

  assign tmr_out   = tmr_out_q;
  assign valid_out = valid_out_q;
  assign mismatch  = mismatch_q;
  assign multi_err = multi_err_q;
  assign err_cnt_1 = err_cnt_w[0];
  assign err_cnt_2 = err_cnt_w[1];
  assign err_cnt_3 = err_cnt_w[2];
endmodule

// File: tb/tb_tmr_voter_seq.sv
// Directed bench for tmr_voter_seq: a CNT_W=8 instance plus a CNT_W=2 instance sharing stimulus.
module tb_tmr_voter_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_in = 1'b0;
  logic       clr_fault = 1'b0;
  logic [3:0] data_1 = '0, data_2 = '0, data_3 = '0;

  logic [3:0] tmr_out, s_tmr_out;
  logic       valid_out, s_valid_out, multi_err, s_multi_err;
  logic [2:0] mismatch, s_mismatch, fault, s_fault;
  logic [7:0] err_cnt_1, err_cnt_2, err_cnt_3;
  logic [1:0] s_err_cnt_1, s_err_cnt_2, s_err_cnt_3;

  int n_vec = 0;
  int n_err = 0;
  int c8 [3] = '{0, 0, 0};
  int c2 [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  tmr_voter_seq #(.WIDTH(4), .FAULT_THRESH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .clr_fault(clr_fault), .tmr_out(tmr_out), .valid_out(valid_out), .mismatch(mismatch),
    .multi_err(multi_err), .fault(fault), .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2),
    .err_cnt_3(err_cnt_3));

  tmr_voter_seq #(.WIDTH(4), .FAULT_THRESH(3), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .clr_fault(clr_fault), .tmr_out(s_tmr_out), .valid_out(s_valid_out), .mismatch(s_mismatch),
    .multi_err(s_multi_err), .fault(s_fault), .err_cnt_1(s_err_cnt_1), .err_cnt_2(s_err_cnt_2),
    .err_cnt_3(s_err_cnt_3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int v);
`ifdef TMR_VOTER_STATS_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic chk_cnts(input string tag);
    chk({tag, ".cnt1"},   {24'd0, err_cnt_1}, stat(c8[0]));
    chk({tag, ".cnt2"},   {24'd0, err_cnt_2}, stat(c8[1]));
    chk({tag, ".cnt3"},   {24'd0, err_cnt_3}, stat(c8[2]));
    chk({tag, ".s_cnt3"}, {30'd0, s_err_cnt_3}, stat(c2[2]));
  endtask

  // Drive one vector at negedge, sample 1 time unit after the following posedge.
  task automatic step(input string tag, input logic [3:0] d1, d2, d3, input logic v, c,
                      input logic [3:0] eo, input logic [2:0] em, input logic emu,
                      input logic [2:0] ef);
    @(negedge clk);
    data_1 = d1; data_2 = d2; data_3 = d3; valid_in = v; clr_fault = c;
    @(posedge clk);
    #1;
    if (v) for (int i = 0; i < 3; i++) if (em[i]) begin
      if (c8[i] < 255) c8[i]++;
      if (c2[i] < 3) c2[i]++;
    end
    chk({tag, ".vout"},  {31'd0, valid_out}, {31'd0, v});
    chk({tag, ".out"},   {28'd0, tmr_out}, {28'd0, eo});
    chk({tag, ".mis"},   {29'd0, mismatch}, {29'd0, em});
    chk({tag, ".multi"}, {31'd0, multi_err}, {31'd0, emu});
    chk({tag, ".fault"}, {29'd0, fault}, {29'd0, ef});
    chk({tag, ".s_fault"}, {29'd0, s_fault}, {29'd0, ef});
    chk_cnts(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".vout"},  {31'd0, valid_out}, 32'd0);
    chk({tag, ".out"},   {28'd0, tmr_out}, 32'd0);
    chk({tag, ".mis"},   {29'd0, mismatch}, 32'd0);
    chk({tag, ".multi"}, {31'd0, multi_err}, 32'd0);
    chk({tag, ".fault"}, {29'd0, fault}, 32'd0);
    chk({tag, ".s_fault"}, {29'd0, s_fault}, 32'd0);
    chk({tag, ".s_vout"}, {31'd0, s_valid_out}, 32'd0);
    chk({tag, ".cnt1"},  {24'd0, err_cnt_1}, 32'd0);
    chk({tag, ".cnt2"},  {24'd0, err_cnt_2}, 32'd0);
    chk({tag, ".cnt3"},  {24'd0, err_cnt_3}, 32'd0);
    chk({tag, ".s_cnt3"}, {30'd0, s_err_cnt_3}, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    step("basic",   4'b1011, 4'b1011, 4'b1111, 1, 0, 4'b1011, 3'b100, 0, 3'b000);
    step("hold",    4'b0000, 4'b1111, 4'b0000, 0, 0, 4'b1011, 3'b100, 0, 3'b000);
    step("ch1_a",   4'b1111, 4'b1001, 4'b1001, 1, 0, 4'b1001, 3'b001, 0, 3'b000);
    step("ch1_b",   4'b1111, 4'b1001, 4'b1001, 1, 0, 4'b1001, 3'b001, 0, 3'b000);
    step("ch1_c",   4'b1111, 4'b1001, 4'b1001, 1, 0, 4'b1001, 3'b001, 0, 3'b001);
    step("allbad",  4'b0001, 4'b0010, 4'b0100, 1, 0, 4'b0000, 3'b111, 1, 3'b001);
    step("clean",   4'b0101, 4'b0101, 4'b0101, 1, 0, 4'b0101, 3'b000, 0, 3'b001);
    step("ch2_a",   4'b0101, 4'b0100, 4'b0101, 1, 0, 4'b0101, 3'b010, 0, 3'b001);
    step("ch2_b",   4'b0101, 4'b0100, 4'b0101, 1, 0, 4'b0101, 3'b010, 0, 3'b001);
    step("ch2_ok",  4'b0101, 4'b0101, 4'b0101, 1, 0, 4'b0101, 3'b000, 0, 3'b001);
    step("ch2_c",   4'b0101, 4'b0100, 4'b0101, 1, 0, 4'b0101, 3'b010, 0, 3'b001);
    step("clr",     4'b1000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 3'b001, 0, 3'b000);
    step("ch3_a",   4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, 3'b100, 0, 3'b000);
    step("ch3_b",   4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, 3'b100, 0, 3'b000);
    step("ch3_c",   4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, 3'b100, 0, 3'b100);
    step("ch3_d",   4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, 3'b100, 0, 3'b100);
    step("ch3_e",   4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, 3'b100, 0, 3'b100);

    // Reset lands between drive and sampling edge: in-flight sample is dropped.
    @(negedge clk);
    data_1 = 4'b1111; data_2 = 4'b1111; data_3 = 4'b0000; valid_in = 1'b1; clr_fault = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin c8[i] = 0; c2[i] = 0; end
    @(posedge clk);
    #1 chk_zero("postrst");
    step("first",   4'b0011, 4'b0011, 4'b0011, 1, 0, 4'b0011, 3'b000, 0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
